// File: rtl/nes_controller_reader_if.sv
// nes_controller_reader_if: controller pins plus decoded button outputs.
// master = the reader (drives latch/pulse and button levels),
// slave  = the gamepad / downstream consumer side.
interface nes_controller_reader_if;
  logic       nes_data;
  logic       nes_latch;
  logic       nes_pulse;
  logic [7:0] buttons;
  logic       forward;
  logic       backward;
  logic       left;
  logic       right;
  logic       frame_valid;

  modport master (
    input  nes_data,
    output nes_latch, nes_pulse, buttons,
    output forward, backward, left, right, frame_valid
  );

  modport slave (
    output nes_data,
    input  nes_latch, nes_pulse, buttons,
    input  forward, backward, left, right, frame_valid
  );
endinterface

// File: rtl/nes_controller_reader.sv
// nes_controller_reader: polls an NES gamepad over latch/pulse/data and
// presents the eight buttons as registered active-high levels, with a
// one-cycle frame_valid strobe per completed frame.
//
// Optional build macro NES_DEBOUNCE_EN: buttons only update when two
// consecutive frames read the same shadow value.
//
// The state/counter registers describe the cycle that the *next* clock
// edge emits; all controller outputs are registered from them, so the
// first edge after reset release already drives nes_latch high.
module nes_controller_reader #(
  parameter int LATCH_CYCLES = 600,
  parameter int HALF_CYCLES  = 300,
  parameter int POLL_CYCLES  = 833333
) (
  input  logic                   clk,
  input  logic                   reset,
  nes_controller_reader_if.master bus
);

  localparam int PW     = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int PH_MAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
  localparam int CW     = $clog2(PH_MAX + 1);

  localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYCLES - 1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_CYCLES - 1);
  localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_CYCLES - 1);

  typedef enum logic [2:0] {
    S_LATCH,
    S_GAP,
    S_PULSE_HI,
    S_PULSE_LO,
    S_DONE,
    S_WAIT
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] phase_cnt, phase_d;
  logic [2:0]    bit_idx, bit_d;
  logic [PW-1:0] poll_cnt, poll_d;
  logic [7:0]    shadow, shadow_d;
  logic [7:0]    btn_q, btn_d;
  logic          latch_q, latch_d;
  logic          pulse_q, pulse_d;
  logic          fv_q, fv_d;
  logic [1:0]    sync_pipe;
  logic          data_s;

`ifdef NES_DEBOUNCE_EN
  logic [7:0]    prev_q, prev_d;
`endif

  // Two-flop synchroniser for the asynchronous, idle-high data pin.
  always_ff @(posedge clk) begin
    if (reset) sync_pipe <= 2'b11;
    else       sync_pipe <= {sync_pipe[0], bus.nes_data};
  end

  assign data_s = sync_pipe[1];

  // Next-state, counter, sampling and output decode for the frame sequencer.
  always_comb begin
    state_d  = state;
    phase_d  = phase_cnt + 1'b1;
    bit_d    = bit_idx;
    poll_d   = poll_cnt + 1'b1;
    shadow_d = shadow;
    btn_d    = btn_q;
    latch_d  = 1'b0;
    pulse_d  = 1'b0;
    fv_d     = 1'b0;
`ifdef NES_DEBOUNCE_EN
    prev_d   = prev_q;
`endif
    case (state)
      S_LATCH: begin
        latch_d = 1'b1;
        if (phase_cnt == LATCH_LAST) begin
          state_d = S_GAP;
          phase_d = '0;
        end
      end
      S_GAP: begin
        // Bit 0 (A) is presented by the pad as soon as latch drops.
        if (phase_cnt == HALF_LAST) begin
          shadow_d[0] = ~data_s;
          bit_d       = 3'd1;
          state_d     = S_PULSE_HI;
          phase_d     = '0;
        end
      end
      S_PULSE_HI: begin
        pulse_d = 1'b1;
        if (phase_cnt == HALF_LAST) begin
          state_d = S_PULSE_LO;
          phase_d = '0;
        end
      end
      S_PULSE_LO: begin
        // Sample late in the low phase so the pad's shift has settled.
        if (phase_cnt == HALF_LAST) begin
          shadow_d[bit_idx] = ~data_s;
          phase_d           = '0;
          if (bit_idx == 3'd7) begin
            state_d = S_DONE;
          end else begin
            bit_d   = bit_idx + 3'd1;
            state_d = S_PULSE_HI;
          end
        end
      end
      S_DONE: begin
        fv_d    = 1'b1;
        phase_d = '0;
        state_d = S_WAIT;
`ifdef NES_DEBOUNCE_EN
        if (shadow == prev_q) btn_d = shadow;
        prev_d = shadow;
`else
        btn_d = shadow;
`endif
      end
      S_WAIT: begin
        phase_d = '0;
        if (poll_cnt == POLL_LAST) begin
          state_d = S_LATCH;
          poll_d  = '0;
        end
      end
      default: begin
        state_d = S_LATCH;
        phase_d = '0;
        poll_d  = '0;
      end
    endcase
  end

  // Sequencer state, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_LATCH;
      phase_cnt <= '0;
      bit_idx   <= '0;
      poll_cnt  <= '0;
      shadow    <= '0;
      btn_q     <= '0;
      latch_q   <= 1'b0;
      pulse_q   <= 1'b0;
      fv_q      <= 1'b0;
`ifdef NES_DEBOUNCE_EN
      prev_q    <= '0;
`endif
    end else begin
      state     <= state_d;
      phase_cnt <= phase_d;
      bit_idx   <= bit_d;
      poll_cnt  <= poll_d;
      shadow    <= shadow_d;
      btn_q     <= btn_d;
      latch_q   <= latch_d;
      pulse_q   <= pulse_d;
      fv_q      <= fv_d;
`ifdef NES_DEBOUNCE_EN
      prev_q    <= prev_d;
`endif
    end
  end

  assign bus.nes_latch   = latch_q;
  assign bus.nes_pulse   = pulse_q;
  assign bus.buttons     = btn_q;
  assign bus.frame_valid = fv_q;
  assign bus.forward     = btn_q[4];
  assign bus.backward    = btn_q[5];
  assign bus.left        = btn_q[6];
  assign bus.right       = btn_q[7];

endmodule
